// File: rtl/greenhouse_pkg.sv
// Shared definitions for the greenhouse actuator scheduler: channel map, state
// encodings, the NUTRI/FLUSH exclusion mask and small arbitration helpers.
package greenhouse_pkg;

    localparam int NUM_CH   = 5;
    localparam int CH_NUTRI = 0;
    localparam int CH_WATER = 1;
    localparam int CH_TEMP  = 2;
    localparam int CH_SPRAY = 3;
    localparam int CH_FLUSH = 4;
    localparam int CH_GAS   = 5;

    typedef enum logic [1:0] {
        CH_OFF  = 2'd0,
        CH_ON   = 2'd1,
        CH_COOL = 2'd2
    } ch_state_t;

    typedef enum logic {
        TOP_NORMAL   = 1'b0,
        TOP_GAS_LOCK = 1'b1
    } top_state_t;

    // Channels that may never be on together.
    localparam logic [NUM_CH-1:0] EXCL_MASK = 5'b10001;

    // One-hot pick of the first candidate at or after ptr, wrapping over 0..4.
    function automatic logic [NUM_CH-1:0] rr_pick(input logic [NUM_CH-1:0] cand,
                                                  input logic [2:0]        ptr);
        logic [NUM_CH-1:0] pick;
        int                idx;
        pick = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            idx = (int'(ptr) + k) % NUM_CH;
            if (cand[idx] && (pick == '0)) begin
                pick[idx] = 1'b1;
            end
        end
        return pick;
    endfunction

    function automatic logic [2:0] count_ones(input logic [NUM_CH-1:0] v);
        logic [2:0] n;
        n = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            n = n + {2'b00, v[k]};
        end
        return n;
    endfunction

endpackage

// File: rtl/greenhouse_channel_timer.sv
// Per-channel OFF -> ON -> COOL -> OFF sequencer. The timer holds on-time while
// ON (saturating at MAX_ON) and the remaining cooldown while COOL.
module greenhouse_channel_timer
    import greenhouse_pkg::*;
#(
    parameter int MIN_ON   = 4,
    parameter int MAX_ON   = 16,
    parameter int COOLDOWN = 2,
    parameter int CNT_W    = 5
) (
    input  logic      clk,
    input  logic      reset,
    input  logic      req,
    input  logic      grant,
    input  logic      revoke,
    input  logic      force_off,
    output ch_state_t state,
    output logic      on,
    output logic      min_met,
    output logic      max_hit
);

    ch_state_t        state_q, state_d;
    logic [CNT_W-1:0] timer_q, timer_d;

    // NOTE: registers take <= so every flop samples pre-edge values; the
    // combinational block below uses = because it describes plain logic.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= CH_OFF;
            timer_q <= '0;
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
        end
    end

    assign state   = state_q;
    assign on      = (state_q == CH_ON);
    assign min_met = on && (timer_q >= CNT_W'(MIN_ON));
    assign max_hit = on && (timer_q >= CNT_W'(MAX_ON));

    // NOTE: defaults first so no path leaves state_d/timer_d unassigned (no latch).
    always_comb begin
        state_d = state_q;
        timer_d = timer_q;
        unique case (state_q)
            CH_OFF: begin
                if (grant) begin
                    state_d = CH_ON;
                    timer_d = CNT_W'(1);
                end
            end
            CH_ON: begin
                if (force_off || revoke || (!req && min_met)) begin
                    state_d = CH_COOL;
                    timer_d = CNT_W'(COOLDOWN);
                end else if (!max_hit) begin
                    timer_d = timer_q + CNT_W'(1);
                end
            end
            CH_COOL: begin
                if (timer_q <= CNT_W'(1)) begin
                    state_d = CH_OFF;
                    timer_d = '0;
                end else begin
                    timer_d = timer_q - CNT_W'(1);
                end
            end
            default: begin
                state_d = CH_OFF;
                timer_d = '0;
            end
        endcase
    end

endmodule

// File: rtl/greenhouse_actuator_scheduler.sv
// Shares the actuator power budget among channels 0..4 with round-robin grants,
// NUTRI/FLUSH exclusion and a GAS_LOCK override that forces everything else off.
module greenhouse_actuator_scheduler
    import greenhouse_pkg::*;
#(
    parameter int MAX_ACTIVE = 2,
    parameter int MIN_ON     = 4,
    parameter int MAX_ON     = 16,
    parameter int COOLDOWN   = 2,
    parameter int CNT_W      = 5
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] S,
    output logic [5:0] A,
    output logic [2:0] active_cnt,
    output logic [5:0] waiting,
    output logic       gas_lock
);

    ch_state_t         ch_state [NUM_CH];
    logic [NUM_CH-1:0] ch_on, min_met, max_hit;
    logic [NUM_CH-1:0] off_vec, excl_ok, pending, cand;
    logic [NUM_CH-1:0] grant_pre, grant, revoke, release_vec;
    top_state_t        top_q, top_d;
    logic [2:0]        rr_q, rr_d;
    logic              gas_req, grant_ok;

    assign gas_req = S[CH_GAS];

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        greenhouse_channel_timer #(
            .MIN_ON   (MIN_ON),
            .MAX_ON   (MAX_ON),
            .COOLDOWN (COOLDOWN),
            .CNT_W    (CNT_W)
        ) u_timer (
            .clk       (clk),
            .reset     (reset),
            .req       (S[i]),
            .grant     (grant[i]),
            .revoke    (revoke[i]),
            .force_off (gas_req),
            .state     (ch_state[i]),
            .on        (ch_on[i]),
            .min_met   (min_met[i]),
            .max_hit   (max_hit[i])
        );
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            top_q <= TOP_NORMAL;
            rr_q  <= '0;
        end else begin
            top_q <= top_d;
            rr_q  <= rr_d;
        end
    end

    // Gas presence alone decides the top state; grants pause for the exit cycle too.
    always_comb begin
        top_d = top_q;
        unique case (top_q)
            TOP_NORMAL:   if (gas_req)  top_d = TOP_GAS_LOCK;
            TOP_GAS_LOCK: if (!gas_req) top_d = TOP_NORMAL;
            default:      top_d = TOP_NORMAL;
        endcase
    end

    assign grant_ok = (top_q == TOP_NORMAL) && !gas_req;

    always_comb begin
        off_vec     = '0;
        excl_ok     = '1;
        grant_pre   = '0;
        grant       = '0;
        revoke      = '0;
        release_vec = '0;
        rr_d        = rr_q;
        for (int i = 0; i < NUM_CH; i++) begin
            off_vec[i] = (ch_state[i] == CH_OFF);
        end
        // An exclusive channel may start only when its partner is fully OFF.
        for (int i = 0; i < NUM_CH; i++) begin
            if (EXCL_MASK[i]) begin
                excl_ok[i] = &(off_vec | ~EXCL_MASK | (NUM_CH'(1) << i));
            end
        end
        pending = S[NUM_CH-1:0] & off_vec;
        cand    = pending & excl_ok;

        // Revocation looks at waiters left over after a grant that needs no freed slot.
        if (grant_ok && (int'(active_cnt) < MAX_ACTIVE)) begin
            grant_pre = rr_pick(cand, rr_q);
        end
        revoke      = max_hit & {NUM_CH{|(pending & ~grant_pre)}};
        release_vec = ch_on & ((~S[NUM_CH-1:0] & min_met) | revoke);

        if (grant_ok && ((int'(active_cnt) - int'(count_ones(release_vec))) < MAX_ACTIVE)) begin
            grant = rr_pick(cand, rr_q);
        end
        for (int i = 0; i < NUM_CH; i++) begin
            if (grant[i]) begin
                rr_d = (i == NUM_CH - 1) ? 3'd0 : 3'(i + 1);
            end
        end
    end

    assign gas_lock   = (top_q == TOP_GAS_LOCK);
    assign A          = {gas_lock, ch_on};
    assign active_cnt = count_ones(ch_on);
    assign waiting    = {1'b0, pending & ~grant};

endmodule

// File: tb/tb_greenhouse_actuator_scheduler.sv
// Directed scenarios followed by randomized traffic, all compared every cycle
// against a behavioural model of the scheduling rules.
module tb_greenhouse_actuator_scheduler;

    localparam int PERIOD     = 20;
    localparam int MAX_ACTIVE = 2;
    localparam int MIN_ON     = 4;
    localparam int MAX_ON     = 16;
    localparam int COOLDOWN   = 2;

    logic       clk = 1'b0;
    logic       reset;
    logic [5:0] S;
    logic [5:0] A;
    logic [2:0] active_cnt;
    logic [5:0] waiting;
    logic       gas_lock;

    int checks = 0;
    int passed = 0;
    int fails  = 0;

    // Model: on_time > 0 means on; cool_left > 0 means cooling; both 0 means off.
    int on_time   [5];
    int cool_left [5];
    int rr;
    bit lock;
    int m_grant;
    bit m_release [5];
    logic [5:0] m_waiting;

    always #(PERIOD/2) clk = ~clk;

    greenhouse_actuator_scheduler dut (
        .clk        (clk),
        .reset      (reset),
        .S          (S),
        .A          (A),
        .active_cnt (active_cnt),
        .waiting    (waiting),
        .gas_lock   (gas_lock)
    );

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic bit is_off(input int i);
        return (on_time[i] == 0) && (cool_left[i] == 0);
    endfunction

    function automatic int count_on();
        int n = 0;
        for (int i = 0; i < 5; i++) if (on_time[i] > 0) n++;
        return n;
    endfunction

    function automatic int pick(input logic [5:0] s);
        for (int k = 0; k < 5; k++) begin
            int i;
            bit ok;
            i  = (rr + k) % 5;
            ok = (i == 0) ? is_off(4) : (i == 4) ? is_off(0) : 1'b1;
            if (s[i] && is_off(i) && ok) return i;
        end
        return -1;
    endfunction

    function automatic logic [5:0] model_a();
        logic [5:0] a;
        a = '0;
        for (int i = 0; i < 5; i++) a[i] = (on_time[i] > 0);
        a[5] = lock;
        return a;
    endfunction

    // Decide this cycle's grant, releases and waiting set from the rules.
    task automatic model_eval(input logic [5:0] s);
        bit normal_ok, any_wait;
        int pre, n_after;
        normal_ok = !lock && !s[5];
        pre = (normal_ok && count_on() < MAX_ACTIVE) ? pick(s) : -1;
        any_wait = 1'b0;
        for (int j = 0; j < 5; j++) if (s[j] && is_off(j) && j != pre) any_wait = 1'b1;
        n_after = count_on();
        for (int i = 0; i < 5; i++) begin
            m_release[i] = (on_time[i] > 0) &&
                           (s[5] || (!s[i] && on_time[i] >= MIN_ON) ||
                            (on_time[i] >= MAX_ON && any_wait));
            if (m_release[i]) n_after--;
        end
        m_grant = (normal_ok && n_after < MAX_ACTIVE) ? pick(s) : -1;
        m_waiting = '0;
        for (int j = 0; j < 5; j++) m_waiting[j] = s[j] && is_off(j) && (j != m_grant);
    endtask

    task automatic model_step(input logic [5:0] s, input logic rst);
        if (rst) begin
            for (int i = 0; i < 5; i++) begin
                on_time[i] = 0;
                cool_left[i] = 0;
            end
            rr = 0;
            lock = 1'b0;
            return;
        end
        model_eval(s);
        for (int i = 0; i < 5; i++) begin
            if (cool_left[i] > 0) begin
                cool_left[i]--;
            end else if (on_time[i] > 0) begin
                if (m_release[i]) begin
                    on_time[i] = 0;
                    cool_left[i] = COOLDOWN;
                end else if (on_time[i] < MAX_ON) begin
                    on_time[i]++;
                end
            end else if (i == m_grant) begin
                on_time[i] = 1;
            end
        end
        if (m_grant >= 0) rr = (m_grant + 1) % 5;
        lock = s[5];
    endtask

    task automatic cycle(input logic [5:0] s, input logic rst);
        @(negedge clk);
        S = s;
        reset = rst;
        #2;
        if (!rst) begin
            model_eval(s);
            check("waiting", {2'b00, waiting}, {2'b00, m_waiting});
        end
        @(posedge clk);
        model_step(s, rst);
        #1;
        check("A", {2'b00, A}, {2'b00, model_a()});
        check("active_cnt", {5'b0, active_cnt}, 8'(count_on()));
        check("gas_lock", {7'b0, gas_lock}, {7'b0, lock});
    endtask

    task automatic repeat_cycle(input logic [5:0] s, input int n);
        for (int k = 0; k < n; k++) cycle(s, 1'b0);
    endtask

    initial begin
        logic [5:0] rs;
        int hold;
        S = '0;
        reset = 1'b1;
        model_step('0, 1'b1);

        // Reset with every request asserted.
        cycle(6'b111111, 1'b1);
        cycle(6'b111111, 1'b1);

        // Minimum on-time, then re-grant after cooldown.
        repeat_cycle(6'b000000, 2);
        repeat_cycle(6'b000010, 2);
        repeat_cycle(6'b000000, 3);
        repeat_cycle(6'b000010, 5);
        repeat_cycle(6'b000000, 8);

        // Concurrency limit, round-robin and MAX_ON revocation.
        cycle(6'b000000, 1'b1);
        repeat_cycle(6'b001110, 24);

        // Gas preemption and recovery.
        cycle(6'b000000, 1'b1);
        repeat_cycle(6'b000110, 3);
        repeat_cycle(6'b100110, 3);
        repeat_cycle(6'b000110, 6);

        // NUTRI/FLUSH exclusion.
        cycle(6'b000000, 1'b1);
        repeat_cycle(6'b010001, 3);
        repeat_cycle(6'b010000, 10);
        repeat_cycle(6'b000000, 4);
        repeat_cycle(6'b010001, 2);
        repeat_cycle(6'b000001, 10);

        // Mid-operation reset, then confirm round-robin restarts at 0.
        cycle(6'b000000, 1'b1);
        repeat_cycle(6'b000110, 4);
        cycle(6'b000110, 1'b1);
        repeat_cycle(6'b000111, 3);

        // Randomized traffic with occasional gas and reset.
        for (int n = 0; n < 150; n++) begin
            rs = 6'($urandom_range(0, 31));
            if ($urandom_range(0, 11) == 0) rs[5] = 1'b1;
            hold = $urandom_range(1, 8);
            for (int k = 0; k < hold; k++) cycle(rs, ($urandom_range(0, 199) == 0));
        end

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
